// File: rtl/dcs_pkg.sv
// dcs_pkg: shared types, sizes and the leading-one helper for the vector re-quantiser.
package dcs_pkg;
    localparam int N       = 8;
    localparam int IN_W    = 32;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 5;
    localparam int IDX_W   = $clog2(N);

    typedef enum logic [1:0] {COLLECT, SCAN, EMIT} state_e;

    function automatic logic [SHIFT_W-1:0] lead_one_pos(input logic [IN_W-1:0] x);
        logic [SHIFT_W-1:0] p;
        p = '0;
        for (int i = 0; i < IN_W; i++)
            if (x[i]) p = SHIFT_W'(i);
        return p;
    endfunction
endpackage

// File: rtl/dcs_round_sat.sv
// dcs_round_sat: right-shift with round-half-up, saturating to OUT_W bits.
module dcs_round_sat
    import dcs_pkg::*;
(
    input  logic [IN_W-1:0]    x_i,
    input  logic [SHIFT_W-1:0] s_i,
    output logic [OUT_W-1:0]   q_o
);
    logic [IN_W:0] half;
    logic [IN_W:0] sum;
    logic [IN_W:0] r;

    // the extra bit keeps the rounding carry of a full-scale input
    always_comb begin
        half = (IN_W+1)'(1) << (s_i - SHIFT_W'(1));
        sum  = {1'b0, x_i} + half;
        r    = sum >> s_i;
        q_o  = (s_i == '0) ? x_i[OUT_W-1:0]
             : (r > (IN_W+1)'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : r[OUT_W-1:0];
    end
endmodule

// File: rtl/dcs_vec_requant.sv
// dcs_vec_requant: collects an N-word result vector, finds max/argmax and a
// power-of-two shift, then streams the re-quantised bytes on valid/ready.
module dcs_vec_requant
    import dcs_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic [IDX_W-1:0]   argmax,
    output logic [SHIFT_W-1:0] shift,
    output logic               overrun
);
    state_e             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   el_q;
    logic [IN_W-1:0]    buf_q [N];
    logic [IN_W-1:0]    max_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   argmax_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [OUT_W-1:0]   out_data_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic               overrun_q;

    logic [SHIFT_W-1:0] p_d;
    logic [SHIFT_W-1:0] s_d;
    logic [IN_W-1:0]    qx_d;
    logic [SHIFT_W-1:0] qs_d;
    logic [OUT_W-1:0]   q_d;

    // one quantiser serves both the first element (fresh shift) and later ones
    always_comb begin
        p_d  = lead_one_pos(max_q);
        s_d  = (p_d >= SHIFT_W'(OUT_W)) ? p_d - SHIFT_W'(OUT_W - 1) : '0;
        qx_d = (state_q == SCAN) ? buf_q[0] : buf_q[el_q + IDX_W'(1)];
        qs_d = (state_q == SCAN) ? s_d : shift_q;
    end

    dcs_round_sat u_round_sat (
        .x_i (qx_d),
        .s_i (qs_d),
        .q_o (q_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            el_q        <= '0;
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            argmax_q    <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: if (in_valid) begin
                    buf_q[cnt_q] <= in_data;
                    cnt_q        <= cnt_q + IDX_W'(1);
                    if (in_data > max_q) begin
                        max_q <= in_data;
                        idx_q <= cnt_q;
                    end
                    if (cnt_q == IDX_W'(N - 1)) state_q <= SCAN;
                end
                SCAN: begin
                    shift_q     <= s_d;
                    argmax_q    <= idx_q;
                    out_data_q  <= q_d;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (N == 1);
                    el_q        <= '0;
                    state_q     <= EMIT;
                end
                EMIT: if (out_ready) begin
                    if (el_q == IDX_W'(N - 1)) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        max_q       <= '0;
                        idx_q       <= '0;
                        state_q     <= COLLECT;
                    end else begin
                        el_q       <= el_q + IDX_W'(1);
                        out_data_q <= q_d;
                        out_last_q <= (el_q == IDX_W'(N - 2));
                    end
                end
                default: state_q <= COLLECT;
            endcase
            if (in_valid && state_q != COLLECT) overrun_q <= 1'b1;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign argmax    = argmax_q;
    assign shift     = shift_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_dcs_vec_requant.sv
// tb_dcs_vec_requant: randomized scoreboard bench for the vector re-quantiser.
module tb_dcs_vec_requant;
    typedef logic [31:0] vec_t [8];
    typedef struct {
        logic [7:0] d;
        logic       l;
        logic [2:0] a;
        logic [4:0] s;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic [31:0] in_data = 0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1;
    logic [7:0]  out_data;
    logic        out_last;
    logic [2:0]  argmax;
    logic [4:0]  shift;
    logic        overrun;

    int   checks = 0;
    int   errors = 0;
    int   mode = 0;
    int   rk = 0;
    exp_t sb[$];

    dcs_vec_requant dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .argmax(argmax),
        .shift(shift), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: pick the largest word (first on ties), scale so it fits 8 bits
    task automatic model(input vec_t v, output int am, output int sh);
        longint unsigned mx = 0;
        int p = 0;
        am = 0;
        for (int i = 0; i < 8; i++)
            if (longint'(v[i]) > mx) begin mx = longint'(v[i]); am = i; end
        for (int i = 0; i < 32; i++)
            if (((mx >> i) & 1) == 1) p = i;
        sh = (mx == 0 || p < 8) ? 0 : p - 7;
        for (int i = 0; i < 8; i++) begin
            longint unsigned x = longint'(v[i]);
            longint unsigned y;
            exp_t e;
            y = (sh == 0) ? (x % 256) : (x + (64'd1 << (sh - 1))) >> sh;
            if (y > 255) y = 255;
            e.d = 8'(y); e.l = (i == 7); e.a = 3'(am); e.s = 5'(sh);
            sb.push_back(e);
        end
    endtask

    // drive out_ready: 0 always ready, 1 random, 2 pattern 1,0,0,...
    always @(posedge clk) begin
        #1;
        rk++;
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (rk % 3 == 0);
    end

    logic       stall_prev = 0;
    logic [7:0] pd;
    logic       pl;
    logic [2:0] pa;
    logic [4:0] ps;

    always @(negedge clk) begin
        if (!rst_n) stall_prev = 0;
        else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(pd));
                chk("stall_last", 32'(out_last), 32'(pl));
                chk("stall_argmax", 32'(argmax), 32'(pa));
                chk("stall_shift", 32'(shift), 32'(ps));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data", 32'(out_data), 32'(e.d));
                    chk("last", 32'(out_last), 32'(e.l));
                    chk("argmax", 32'(argmax), 32'(e.a));
                    chk("shift", 32'(shift), 32'(e.s));
                end
            end
            stall_prev = out_valid && !out_ready;
            pd = out_data; pl = out_last; pa = argmax; ps = shift;
        end
    end

    task automatic send(input vec_t v, input int cnt, input int gap, input bit lat);
        int t = 0;
        int am, sh;
        while (!in_ready && t < 500) begin @(posedge clk); #1; t++; end
        chk("in_ready_wait", 32'(in_ready), 1);
        for (int i = 0; i < cnt; i++) begin
            in_valid = 1; in_data = v[i];
            if (i == 7) model(v, am, sh);
            @(posedge clk); #1;
            in_valid = 0; in_data = $urandom;
            if (i < cnt - 1) repeat (gap) begin @(posedge clk); #1; end
        end
        if (lat && cnt == 8) begin
            chk("lat_scan_valid", 32'(out_valid), 0);
            chk("lat_scan_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
            chk("lat_first_valid", 32'(out_valid), 1);
            chk("lat_argmax", 32'(argmax), 32'(am));
            chk("lat_shift", 32'(shift), 32'(sh));
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 500) begin @(posedge clk); #1; t++; end
        chk("drain_timeout", 32'(sb.size()), 0);
    endtask

    task automatic do_reset(input logic ovr_before);
        chk("pre_reset_overrun", 32'(overrun), 32'(ovr_before));
        rst_n = 0; #1;
        sb.delete();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_argmax", 32'(argmax), 0);
        chk("rst_shift", 32'(shift), 0);
        chk("rst_overrun", 32'(overrun), 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        #2;
        do_reset(0);
        v = '{10, 20, 30, 40, 50, 60, 70, 80};
        send(v, 8, 0, 1); drain();
        v = '{32'h1000, 32'h0800, 32'h1FFF, 32'h1FFF, 0, 1, 32'h0180, 32'h7F};
        send(v, 8, 0, 1); drain();
        v = '{default: 32'hFFFF_FFFF};
        send(v, 8, 0, 1); drain();
        v = '{default: 0};
        send(v, 8, 0, 1); drain();
        mode = 2;
        v = '{10, 20, 30, 40, 50, 60, 70, 80};
        send(v, 8, 3, 0); drain();
        v = '{32'h1000, 32'h0800, 32'h1FFF, 32'h1FFF, 0, 1, 32'h0180, 32'h7F};
        send(v, 8, 0, 0);
        begin
            int t = 0;
            while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
        end
        chk("overrun_before", 32'(overrun), 0);
        in_valid = 1; in_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        in_valid = 0;
        chk("overrun_set", 32'(overrun), 1);
        drain();
        chk("overrun_sticky", 32'(overrun), 1);
        mode = 1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 8; i++) v[i] = $urandom >> $urandom_range(0, 31);
            if (k == 2) v[5] = v[1];
            send(v, 8, $urandom_range(0, 2), 0); drain();
        end
        chk("overrun_still", 32'(overrun), 1);
        v = '{1, 2, 3, 4, 5, 6, 7, 8};
        send(v, 5, 0, 0);
        do_reset(1);
        v = '{32'h0123_4567, 32'h89AB_CDEF, 5, 32'h0FFF_FFFF, 0, 32'hFFFF, 7, 32'h8000_0000};
        send(v, 8, 1, 0);
        begin
            int t = 0;
            while (sb.size() > 5 && t < 100) begin @(posedge clk); #1; t++; end
        end
        do_reset(0);
        mode = 0;
        v = '{10, 20, 30, 40, 50, 60, 70, 80};
        send(v, 8, 0, 1); drain();
        chk("final_overrun", 32'(overrun), 0);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
